// File: rtl/gps_chan_ctrl_if.sv
// Control/status bundle between the GPS channel sequencer and its datapath/host.
// master drives the controls and epoch data; slave is the sequencer itself.
interface gps_chan_ctrl_if #(
  parameter int PWR_W = 65
);
  logic               start;
  logic               abort;
  logic [PWR_W-1:0]   thresh;
  logic               epoch;
  logic [PWR_W-1:0]   power;
  logic               code_slip;
  logic signed [31:0] dopp_word;
  logic               acc_clr;
  logic               loop_en;
  logic               locked;
  logic               fail;
  logic [2:0]         state;

  modport master (
    output start, abort, thresh, epoch, power,
    input  code_slip, dopp_word, acc_clr, loop_en, locked, fail, state
  );

  modport slave (
    input  start, abort, thresh, epoch, power,
    output code_slip, dopp_word, acc_clr, loop_en, locked, fail, state
  );
endinterface

// File: rtl/gps_chan_ctrl.sv
// GPS channel acquisition/tracking sequencer: code x Doppler grid search, verify, pull-in, track.
// Optional macro GPS_CHAN_REACQ_EN: after loss of track, search restarts at the bin held at loss.
module gps_chan_ctrl #(
  parameter int CODE_STEPS    = 2046,
  parameter int DOPP_BINS     = 21,
  parameter int DOPP_STEP     = 500,
  parameter int DWELL         = 1,
  parameter int PULLIN_EPOCHS = 200,
  parameter int LOSS_N        = 20,
  parameter int PWR_W         = 65
) (
  input  logic           clk,
  input  logic           rst,
  gps_chan_ctrl_if.slave bus
);

  localparam int CELL_W = (CODE_STEPS > 1) ? $clog2(CODE_STEPS) : 1;
  localparam int BIN_W  = (DOPP_BINS > 1) ? $clog2(DOPP_BINS) : 1;
  localparam int DW_W   = $clog2(DWELL + 1);
  localparam int PI_W   = $clog2(PULLIN_EPOCHS + 1);
  localparam int LS_W   = $clog2(LOSS_N + 1);

  localparam logic [CELL_W-1:0] CELL_LAST   = CELL_W'(CODE_STEPS - 1);
  localparam logic [BIN_W-1:0]  BIN_LAST    = BIN_W'(DOPP_BINS - 1);
  localparam logic [DW_W-1:0]   DWELL_LAST  = DW_W'(DWELL - 1);
  localparam logic [PI_W-1:0]   PULLIN_LAST = PI_W'(PULLIN_EPOCHS - 1);
  localparam logic [LS_W-1:0]   LOSS_LAST   = LS_W'(LOSS_N - 1);

  localparam logic signed [31:0] HALF_S = 32'(DOPP_BINS / 2);
  localparam logic signed [31:0] STEP_S = 32'(DOPP_STEP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    VERIFY = 3'd2,
    PULLIN = 3'd3,
    TRACK  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CELL_W-1:0]  cell_reg, cell_next;
  logic [BIN_W-1:0]   bin_reg, bin_next;
  logic [BIN_W-1:0]   bins_done_reg, bins_done_next;
  logic [DW_W-1:0]    dwell_reg, dwell_next;
  logic [PI_W-1:0]    pull_reg, pull_next;
  logic [LS_W-1:0]    miss_reg, miss_next;
  logic               settle_reg, settle_next;
  logic               code_slip_reg, code_slip_next;
  logic               acc_clr_reg, acc_clr_next;
  logic               fail_reg, fail_next;
  logic               loop_en_reg, loop_en_next;
  logic               locked_reg, locked_next;
  logic signed [31:0] dopp_reg, dopp_next;

  logic hit;
  logic do_advance;

  function automatic logic signed [31:0] dopp_of(input logic [BIN_W-1:0] b);
    logic signed [31:0] off;
    off = $signed({{(32 - BIN_W){1'b0}}, b}) - HALF_S;
    return off * STEP_S;
  endfunction

  assign hit = (bus.power > bus.thresh);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cell_reg      <= '0;
      bin_reg       <= '0;
      bins_done_reg <= '0;
      dwell_reg     <= '0;
      pull_reg      <= '0;
      miss_reg      <= '0;
      settle_reg    <= 1'b0;
      code_slip_reg <= 1'b0;
      acc_clr_reg   <= 1'b0;
      fail_reg      <= 1'b0;
      loop_en_reg   <= 1'b0;
      locked_reg    <= 1'b0;
      dopp_reg      <= dopp_of('0);
    end else begin
      state_reg     <= state_next;
      cell_reg      <= cell_next;
      bin_reg       <= bin_next;
      bins_done_reg <= bins_done_next;
      dwell_reg     <= dwell_next;
      pull_reg      <= pull_next;
      miss_reg      <= miss_next;
      settle_reg    <= settle_next;
      code_slip_reg <= code_slip_next;
      acc_clr_reg   <= acc_clr_next;
      fail_reg      <= fail_next;
      loop_en_reg   <= loop_en_next;
      locked_reg    <= locked_next;
      dopp_reg      <= dopp_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cell_next      = cell_reg;
    bin_next       = bin_reg;
    bins_done_next = bins_done_reg;
    dwell_next     = dwell_reg;
    pull_next      = pull_reg;
    miss_next      = miss_reg;
    settle_next    = settle_reg;
    code_slip_next = 1'b0;
    acc_clr_next   = 1'b0;
    fail_next      = 1'b0;
    loop_en_next   = loop_en_reg;
    locked_next    = locked_reg;
    do_advance     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next     = SEARCH;
          cell_next      = '0;
          bin_next       = '0;
          bins_done_next = '0;
          dwell_next     = '0;
          settle_next    = 1'b1;
          acc_clr_next   = 1'b1;
        end
      end

      SEARCH, VERIFY: begin
        if (bus.epoch) begin
          // The first epoch after a cell/bin/state change straddles the retune.
          if (settle_reg) begin
            settle_next = 1'b0;
          end else if (dwell_reg != DWELL_LAST) begin
            dwell_next = dwell_reg + DW_W'(1);
          end else begin
            dwell_next = '0;
            if (hit && state_reg == SEARCH) begin
              state_next   = VERIFY;
              settle_next  = 1'b1;
              acc_clr_next = 1'b1;
            end else if (hit) begin
              state_next   = PULLIN;
              loop_en_next = 1'b1;
              pull_next    = '0;
            end else begin
              do_advance = 1'b1;
            end
          end
        end
      end

      PULLIN: begin
        if (bus.epoch) begin
          if (pull_reg == PULLIN_LAST) begin
            state_next  = TRACK;
            locked_next = 1'b1;
            miss_next   = '0;
          end else begin
            pull_next = pull_reg + PI_W'(1);
          end
        end
      end

      TRACK: begin
        if (bus.epoch) begin
          if (hit) begin
            miss_next = '0;
          end else if (miss_reg == LOSS_LAST) begin
            state_next     = SEARCH;
            loop_en_next   = 1'b0;
            locked_next    = 1'b0;
            cell_next      = '0;
            bins_done_next = '0;
            dwell_next     = '0;
            miss_next      = '0;
            settle_next    = 1'b1;
            acc_clr_next   = 1'b1;
`ifdef GPS_CHAN_REACQ_EN
            bin_next       = bin_reg;
`else
            bin_next       = '0;
`endif
          end else begin
            miss_next = miss_reg + LS_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Shared miss handling for SEARCH and VERIFY: step one half-chip, wrap into the next bin.
    if (do_advance) begin
      state_next  = SEARCH;
      settle_next = 1'b1;
      if (cell_reg != CELL_LAST) begin
        cell_next      = cell_reg + CELL_W'(1);
        code_slip_next = 1'b1;
        acc_clr_next   = 1'b1;
      end else if (bins_done_reg == BIN_LAST) begin
        state_next     = IDLE;
        cell_next      = '0;
        bin_next       = '0;
        bins_done_next = '0;
        settle_next    = 1'b0;
        fail_next      = 1'b1;
      end else begin
        cell_next      = '0;
        bin_next       = (bin_reg == BIN_LAST) ? '0 : bin_reg + BIN_W'(1);
        bins_done_next = bins_done_reg + BIN_W'(1);
        code_slip_next = 1'b1;
        acc_clr_next   = 1'b1;
      end
    end

    // abort overrides everything, including a coincident epoch.
    if (bus.abort) begin
      state_next     = IDLE;
      cell_next      = '0;
      bin_next       = '0;
      bins_done_next = '0;
      dwell_next     = '0;
      pull_next      = '0;
      miss_next      = '0;
      settle_next    = 1'b0;
      code_slip_next = 1'b0;
      acc_clr_next   = 1'b0;
      fail_next      = 1'b0;
      loop_en_next   = 1'b0;
      locked_next    = 1'b0;
    end

    // Bin never changes in PULLIN/TRACK, so the word holds there.
    dopp_next = dopp_of(bin_next);
  end

  assign bus.state     = state_reg;
  assign bus.code_slip = code_slip_reg;
  assign bus.acc_clr   = acc_clr_reg;
  assign bus.fail      = fail_reg;
  assign bus.loop_en   = loop_en_reg;
  assign bus.locked    = locked_reg;
  assign bus.dopp_word = dopp_reg;

endmodule

// File: tb/tb_gps_chan_ctrl.sv
// Directed bench for gps_chan_ctrl with a small grid (4 cells x 3 bins, pull-in 5, loss 3).
module tb_gps_chan_ctrl;
  localparam int PWR_W = 65;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   slip_cnt = 0;
  int   le_cnt = 0;
  int   base_slip;
  int   base_le;

  gps_chan_ctrl_if #(.PWR_W(PWR_W)) bus ();

  gps_chan_ctrl #(
    .CODE_STEPS   (4),
    .DOPP_BINS    (3),
    .DOPP_STEP    (500),
    .DWELL        (1),
    .PULLIN_EPOCHS(5),
    .LOSS_N       (3),
    .PWR_W        (PWR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.code_slip) slip_cnt++;
    if (bus.loop_en) le_cnt++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic epoch(input logic [PWR_W-1:0] pwr);
    @(negedge clk);
    bus.epoch = 1'b1;
    bus.power = pwr;
    @(negedge clk);
    bus.epoch = 1'b0;
    #1;
    $display("epoch pwr=%0d -> state=%0d slip=%0d dopp=%0d loop_en=%0d locked=%0d fail=%0d",
             pwr, bus.state, bus.code_slip, bus.dopp_word, bus.loop_en, bus.locked, bus.fail);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    $display("start -> state=%0d acc_clr=%0d", bus.state, bus.acc_clr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, bus.state, 0);
    chk({tag, "_dopp"}, bus.dopp_word, -500);
    chk({tag, "_loop_en"}, bus.loop_en, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_slip"}, bus.code_slip, 0);
    chk({tag, "_acc_clr"}, bus.acc_clr, 0);
    chk({tag, "_fail"}, bus.fail, 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.epoch  = 1'b0;
    bus.power  = '0;
    bus.thresh = 65'd10;

    // Reset and IDLE
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    epoch(0);
    epoch(100);
    chk("idle_no_slip", slip_cnt, 0);
    chk("idle_state", bus.state, 0);

    // Empty search over the full grid
    do_start();
    chk("start_state", bus.state, 1);
    chk("start_acc_clr", bus.acc_clr, 1);
    base_slip = slip_cnt;
    for (int i = 1; i <= 24; i++) begin
      epoch(0);
      if (i == 1) chk("settle_no_slip", bus.code_slip, 0);
      if (i == 2) chk("first_miss_slip", bus.code_slip, 1);
      if (i == 7) chk("dopp_bin0", bus.dopp_word, -500);
      if (i == 8) chk("dopp_bin1", bus.dopp_word, 0);
      if (i == 16) chk("dopp_bin2", bus.dopp_word, 500);
    end
    chk("grid_fail", bus.fail, 1);
    chk("grid_final_no_slip", bus.code_slip, 0);
    chk("grid_state", bus.state, 0);
    chk("grid_slips", slip_cnt - base_slip, 11);
    @(negedge clk);
    #1;
    chk("fail_one_cycle", bus.fail, 0);

    // Detect, verify, pull-in, track
    do_start();
    epoch(0);
    epoch(0);
    epoch(100);
    chk("settle_hit_ignored", bus.state, 1);
    epoch(100);
    chk("verify_state", bus.state, 2);
    chk("verify_acc_clr", bus.acc_clr, 1);
    chk("verify_no_slip", bus.code_slip, 0);
    epoch(0);
    chk("verify_settle", bus.state, 2);
    epoch(100);
    chk("pullin_state", bus.state, 3);
    chk("pullin_loop_en", bus.loop_en, 1);
    do_start();
    chk("start_ignored", bus.state, 3);
    for (int i = 1; i <= 4; i++) epoch(0);
    chk("pullin_4_locked", bus.locked, 0);
    chk("pullin_4_state", bus.state, 3);
    epoch(0);
    chk("track_state", bus.state, 4);
    chk("track_locked", bus.locked, 1);
    chk("track_loop_en", bus.loop_en, 1);

    // Loss: 2 misses (one at power == thresh), 1 hit, then 3 misses
    epoch(0);
    epoch(10);
    epoch(100);
    epoch(0);
    epoch(0);
    chk("loss_5_locked", bus.locked, 1);
    epoch(0);
    chk("loss_locked", bus.locked, 0);
    chk("loss_loop_en", bus.loop_en, 0);
    chk("loss_state", bus.state, 1);
    chk("loss_dopp", bus.dopp_word, -500);
    chk("loss_no_slip", bus.code_slip, 0);

    // False alarm: hit in SEARCH, miss in VERIFY
    base_slip = slip_cnt;
    base_le = le_cnt;
    epoch(100);
    epoch(100);
    chk("fa_verify", bus.state, 2);
    epoch(0);
    epoch(0);
    chk("fa_state", bus.state, 1);
    chk("fa_slip", bus.code_slip, 1);
    chk("fa_slips", slip_cnt - base_slip, 1);
    chk("fa_loop_en_seen", le_cnt - base_le, 0);

    // Abort coincident with an epoch in PULLIN
    epoch(0);
    epoch(100);
    epoch(0);
    epoch(100);
    chk("ab_pullin", bus.state, 3);
    epoch(0);
    epoch(0);
    base_slip = slip_cnt;
    @(negedge clk);
    bus.abort = 1'b1;
    bus.epoch = 1'b1;
    bus.power = '0;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.epoch = 1'b0;
    #1;
    $display("abort+epoch -> state=%0d slip=%0d loop_en=%0d", bus.state, bus.code_slip, bus.loop_en);
    chk("abort_state", bus.state, 0);
    chk("abort_loop_en", bus.loop_en, 0);
    chk("abort_slip", bus.code_slip, 0);
    chk("abort_acc_clr", bus.acc_clr, 0);
    chk("abort_slips", slip_cnt - base_slip, 0);

    // Reset coincident with an epoch in PULLIN
    do_start();
    epoch(0);
    epoch(100);
    epoch(0);
    epoch(100);
    epoch(0);
    chk("rs_pullin", bus.state, 3);
    @(negedge clk);
    rst = 1'b0;
    bus.epoch = 1'b1;
    @(negedge clk);
    bus.epoch = 1'b0;
    #1;
    $display("reset+epoch -> state=%0d dopp=%0d loop_en=%0d", bus.state, bus.dopp_word, bus.loop_en);
    check_reset_outputs("midrst");
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
